// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron scheduler.
// Holds the FSM state encoding and default datapath widths.
package lif_pkg;

    localparam int LIF_WIDTH = 8;
    // One extra bit so U - leak + I can be clamped instead of wrapping.
    localparam int LIF_SUM_W = LIF_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } lif_state_e;

endpackage

// File: rtl/lif_update.sv
// Combinational leaky integrate-and-fire update for a single neuron.
// Ports: u_i membrane, w_i weight, cur_i current -> u_next_o, spike_o.
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH      = LIF_WIDTH,
    parameter int BETA_SHIFT = 4,
    parameter int THRESH     = 128
) (
    input  logic [WIDTH-1:0] u_i,
    input  logic [WIDTH-1:0] w_i,
    input  logic [WIDTH-1:0] cur_i,
    output logic [WIDTH-1:0] u_next_o,
    output logic             spike_o
);

    localparam int SUM_W = WIDTH + (LIF_SUM_W - LIF_WIDTH);
    localparam logic [WIDTH-1:0] TH = WIDTH'(THRESH);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   inj;
    logic [WIDTH-1:0]   leak;
    logic [SUM_W-1:0]   sum;
    logic [WIDTH-1:0]   sat;
    logic               fire;

    always_comb begin
        prod = {{WIDTH{1'b0}}, cur_i} * {{WIDTH{1'b0}}, w_i};
        inj  = prod[2*WIDTH-1:WIDTH];
        leak = u_i >> BETA_SHIFT;
        // leak <= u, so the subtraction never underflows.
        sum  = SUM_W'(u_i) - SUM_W'(leak) + SUM_W'(inj);
        sat  = sum[SUM_W-1] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        fire = (sat >= TH);
        u_next_o = fire ? (sat - TH) : sat;
        spike_o  = fire;
    end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF scheduler: one shared update unit walks all neurons
// per tick. Ports: tick/current in, cfg_* weight writes, rd_* membrane
// readback, busy/done status, spike vector, sticky overrun flag.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = 8,
    parameter int WIDTH      = LIF_WIDTH,
    parameter int BETA_SHIFT = 4,
    parameter int THRESH     = 128,
    parameter logic [WIDTH-1:0] WEIGHT_RST = {WIDTH{1'b1}},
    localparam int AW = $clog2(N_NEURONS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic [WIDTH-1:0]     current_i,
    input  logic                 cfg_we_i,
    input  logic [AW-1:0]        cfg_addr_i,
    input  logic [WIDTH-1:0]     cfg_data_i,
    input  logic [AW-1:0]        rd_addr_i,
    output logic [WIDTH-1:0]     rd_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [N_NEURONS-1:0] spike_o,
    output logic                 overrun_o
);

    lif_state_e state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     cur_q;
    logic [WIDTH-1:0]     u_q [N_NEURONS];
    logic [WIDTH-1:0]     w_q [N_NEURONS];
    logic [N_NEURONS-1:0] shadow_q;
    logic [N_NEURONS-1:0] spike_q;
    logic                 overrun_q;

    logic [WIDTH-1:0] u_nxt;
    logic             spk;

    lif_update #(
        .WIDTH      (WIDTH),
        .BETA_SHIFT (BETA_SHIFT),
        .THRESH     (THRESH)
    ) u_upd (
        .u_i      (u_q[cnt_q]),
        .w_i      (w_q[cnt_q]),
        .cur_i    (cur_q),
        .u_next_o (u_nxt),
        .spike_o  (spk)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tick_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                busy_o = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == AW'(N_NEURONS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cur_q     <= '0;
            shadow_q  <= '0;
            spike_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                u_q[i] <= '0;
                w_q[i] <= WEIGHT_RST;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (tick_i) begin
                if (state_q == ST_IDLE) cur_q <= current_i;
                else overrun_q <= 1'b1;
            end
            if (state_q == ST_RUN) begin
                u_q[cnt_q]      <= u_nxt;
                shadow_q[cnt_q] <= spk;
            end
            // Publish the whole timestep at once.
            if (state_q == ST_DONE) spike_q <= shadow_q;
            // The update above read the old weight this cycle.
            if (cfg_we_i) w_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    assign rd_data_o = u_q[rd_addr_i];
    assign spike_o   = spike_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed self-checking bench for lif_scheduler.
// Each timestep runs in a fixed 14-cycle window with scheduled side events.
module tb_lif_scheduler;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [7:0] current;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [7:0] spike;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    int         xt_at = 0;
    int         we_at = 0;
    int         rs_at = 0;
    logic [2:0] we_a  = '0;
    logic [7:0] we_d  = '0;
    int         lat;
    int         nd;

    lif_scheduler dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tick_i     (tick),
        .current_i  (current),
        .cfg_we_i   (cfg_we),
        .cfg_addr_i (cfg_addr),
        .cfg_data_i (cfg_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .busy_o     (busy),
        .done_o     (done),
        .spike_o    (spike),
        .overrun_o  (overrun)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_u(input logic [2:0] a, output logic [7:0] v);
        rd_addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic chk_all_u(input string tag, input logic [7:0] e);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            read_u(3'(i), v);
            chk(tag, v, e);
        end
    endtask

    task automatic chk_u(input string tag, input logic [2:0] a,
                         input logic [7:0] e);
        logic [7:0] v;
        read_u(a, v);
        chk(tag, v, e);
    endtask

    task automatic wr_w(input logic [2:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run_ts(input logic [7:0] cur, output int l, output int n);
        l = -1;
        n = 0;
        current = cur;
        tick = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            tick     = (c == xt_at);
            cfg_we   = (c == we_at);
            cfg_addr = we_a;
            cfg_data = we_d;
            rst      = (c == rs_at);
            if (rs_at != 0 && c == rs_at + 1) chk("rst_mid_busy", busy, 0);
            if (done) begin
                n++;
                if (l < 0) l = c;
            end
        end
        tick   = 1'b0;
        cfg_we = 1'b0;
        rst    = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] u3_exp [5];
        u3_exp = '{8'd32, 8'd62, 8'd91, 8'd118, 8'd15};
        rst = 1'b1;
        tick = 1'b0;
        current = '0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        rd_addr = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spike", spike, 0);
        chk("rst_ovr", overrun, 0);
        chk_all_u("rst_u", 8'd0);

        run_ts(8'd0, lat, nd);
        chk("zero_lat", lat, 9);
        chk("zero_ndone", nd, 1);
        chk("zero_spike", spike, 8'h00);
        chk("zero_ovr", overrun, 0);
        chk_all_u("zero_u", 8'd0);

        run_ts(8'd255, lat, nd);
        chk("max1_spike", spike, 8'hFF);
        chk_all_u("max1_u", 8'd126);
        run_ts(8'd255, lat, nd);
        chk("max2_spike", spike, 8'hFF);
        chk_all_u("max2_u", 8'd127);

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) wr_w(3'(i), (i == 3) ? 8'd128 : 8'd0);
        for (int k = 0; k < 5; k++) begin
            run_ts(8'd64, lat, nd);
            chk_u("w3_u3", 3'd3, u3_exp[k]);
            chk("w3_spike", spike, (k == 4) ? 8'h08 : 8'h00);
        end
        chk_u("w3_u0", 3'd0, 8'd0);

        xt_at = 3;
        run_ts(8'd64, lat, nd);
        xt_at = 0;
        chk("ovr_lat", lat, 9);
        chk("ovr_ndone", nd, 1);
        chk("ovr_flag", overrun, 1);
        run_ts(8'd64, lat, nd);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_ndone2", nd, 1);
        chk_u("ovr_u3", 3'd3, 8'd77);

        rs_at = 4;
        we_at = 4;
        we_a  = 3'd2;
        we_d  = 8'd0;
        run_ts(8'd64, lat, nd);
        rs_at = 0;
        we_at = 0;
        chk("rstm_ndone", nd, 0);
        chk("rstm_spike", spike, 0);
        chk("rstm_ovr", overrun, 0);
        chk_all_u("rstm_u", 8'd0);
        run_ts(8'd255, lat, nd);
        chk("rstm_w_spike", spike, 8'hFF);
        chk_all_u("rstm_w_u", 8'd126);

        we_at = 6;
        we_a  = 3'd5;
        we_d  = 8'd0;
        run_ts(8'd255, lat, nd);
        we_at = 0;
        chk("wmid_spike1", spike, 8'hFF);
        chk_u("wmid_u5_1", 3'd5, 8'd127);
        run_ts(8'd255, lat, nd);
        chk("wmid_spike2", spike, 8'hDF);
        chk_u("wmid_u5_2", 3'd5, 8'd120);
        chk_u("wmid_u4_2", 3'd4, 8'd127);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 Parameter N_NEURONS, 8, number of time-multiplexed neurons (power of two, 2..16).
REQ-002 Parameter WIDTH, 8, membrane/current/weight width in bits.
REQ-003 Parameter BETA_SHIFT, 4, leak as right-shift amount (leak = U >> BETA_SHIFT).
REQ-004 Parameter THRESH, 128, firing threshold (unsigned).
REQ-005 Parameter WEIGHT_RST, 8'hFF, reset value of every weight.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state changes on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 tick  in  1  start one timestep (single-cycle pulse).
REQ-010 current  in  WIDTH  input current, sampled on accepted tick.
REQ-011 cfg_we  in  1  weight write strobe.
REQ-012 cfg_addr  in  log2(N_NEURONS)  weight index.
REQ-013 cfg_data  in  WIDTH  weight value.
REQ-014 rd_addr  in  log2(N_NEURONS)  membrane readback select.
REQ-015 rd_data  out  WIDTH  membrane of neuron rd_addr (combinational read of register).
REQ-016 busy  out  1  timestep in progress.
REQ-017 done  out  1  one-cycle pulse at timestep end.
REQ-018 spike  out  N_NEURONS  spike vector of last completed timestep.
REQ-019 overrun  out  1  sticky: tick arrived while busy.

Function
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN on tick, RUN->DONE after neuron N_NEURONS-1, DONE->IDLE unconditionally.
REQ-021 Tick accepted only in IDLE; current latched in the accept cycle.
REQ-022 RUN updates one neuron per cycle, index 0 first, ascending; tick at cycle T -> neuron i written at edge T+1+i, done high in cycle T+N_NEURONS+1.
REQ-023 busy high in RUN and DONE, low in IDLE.
REQ-024 I_i = (current_latched * w_i) >> WIDTH (upper WIDTH bits of full product).
REQ-025 S_i = U_i - (U_i >> BETA_SHIFT) + I_i, computed at WIDTH+1 bits, saturated to 2^WIDTH-1.
REQ-026 If S_i >= THRESH: spike bit i = 1, U_i <= S_i - THRESH; else spike bit i = 0, U_i <= S_i.
REQ-027 spike register updates all bits simultaneously in DONE cycle; holds until next DONE.
REQ-028 Per-neuron spike results held in shadow register during RUN; spike output never shows partial timestep.
REQ-029 cfg_we accepted in any state; write lands at clock edge; neuron updated in same cycle uses pre-write weight.
REQ-030 Tick in RUN or DONE ignored (no restart, no extra done) and sets overrun; overrun cleared only by rst.
REQ-031 rd_data reflects register contents, including writes made mid-RUN.

Reset
REQ-032 rst returns FSM to IDLE from any state, including mid-RUN, at the next edge.
REQ-033 Reset values: all U_i = 0, all w_i = WEIGHT_RST, spike = 0, shadow = 0, busy = 0, done = 0, overrun = 0, latched current = 0.
REQ-034 rst asserted together with tick or cfg_we: rst wins, both ignored.

Structure
REQ-035 Shared package lif_pkg holds the FSM state enum, WIDTH default and saturating-add width constant.
REQ-036 Per-neuron arithmetic (REQ-024..026) in one combinational sub-module lif_update, instantiated once and shared by all neurons.
REQ-037 Membranes and weights stored in register arrays indexed by neuron counter; no inferred RAM.

Verification
REQ-038 Reset, tick with current=0 -> done exactly at T+9, spike=8'h00, all rd_data=0, overrun=0.
REQ-039 Weights default 255, current=255 -> I=254; tick1 spike=8'hFF, U=126; tick2 S saturates to 255, spike=8'hFF, U=127.
REQ-040 Weights all 0 except w3=128, current=64 (I3=32) -> U3 after ticks 1..4 = 32, 62, 91, 118, spike=0; tick5 spike=8'h08, U3=15.
REQ-041 Tick, then second tick at T+3 -> single done at T+9, overrun=1 stays high across later timesteps until rst.
REQ-042 rst asserted at T+4 mid-RUN -> next cycle busy=0, done never pulses, all U=0, all w=255, spike=0, overrun=0.
REQ-043 cfg_we writing w5=0 in the cycle neuron 5 updates -> that timestep uses old w5; following timestep I5=0.
